// File: rtl/glitch_pkg.sv
// glitch_pkg: shared definitions for the glitch sequencer program store.
//   - sequencer instruction field encodings (opcode, bus select, ack polarity)
//   - loader command opcodes accepted on the store's command port
//   - program-store FSM state type
package glitch_pkg;

  // Sequencer instruction opcodes (instr[11:10])
  localparam logic [1:0] I2C_CHK = 2'b00;
  localparam logic [1:0] DAC_UP  = 2'b01;
  localparam logic [1:0] DELAY   = 2'b10;

  // Bus select and acknowledge polarity fields
  localparam logic PRIV_BUS = 1'b1;
  localparam logic MAIN_BUS = 1'b0;
  localparam logic ACK      = 1'b0;
  localparam logic NAK      = 1'b1;

  // Loader command opcodes
  localparam logic [1:0] CMD_WR_INSTR = 2'b00;
  localparam logic [1:0] CMD_WR_DELAY = 2'b01;
  localparam logic [1:0] CMD_SET_LEN  = 2'b10;
  localparam logic [1:0] CMD_CLEAR    = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } store_state_t;

endpackage

// File: rtl/glitch_prog_ram.sv
// glitch_prog_ram: generic single-write / single-read synchronous RAM.
//   clk   - clock
//   we    - write enable
//   waddr - write address (DEPTH_W bits)
//   wdata - write data (WIDTH bits)
//   raddr - read address (DEPTH_W bits)
//   rdata - registered read data, one cycle after raddr
// A read and write to the same address in one cycle returns the old word.
// Contents are deliberately not reset.
module glitch_prog_ram #(
  parameter int WIDTH   = 8,
  parameter int DEPTH_W = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [DEPTH_W-1:0] waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [DEPTH_W-1:0] raddr,
  output logic [WIDTH-1:0]   rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/glitch_program_store.sv
// glitch_program_store: writable instruction and delay store for the glitch
// sequencer, filled by a host loader over a valid/ready command port.
//   clk, rst        - clock, asynchronous active-high reset
//   cmd_valid/ready - command handshake; ready only in IDLE with lock low
//   cmd_op          - 00 write instr, 01 write delay, 10 set prog_len, 11 clear
//   cmd_addr        - instruction address / delay index
//   cmd_data        - write data / program length
//   lock            - sequencer running, blocks command acceptance
//   instr_pt        - instruction fetch address
//   instr           - fetched instruction (0 when beyond prog_len)
//   instr_valid     - fetched address was inside the program
//   delay_num       - delay fetch index
//   delay_len       - fetched delay length (0 when index out of range)
//   prog_len        - current program length
//   busy            - bulk clear in progress
//   err             - sticky error (dropped write or clamped length)
//   checksum        - mod-2^16 sum of accepted instruction words
//
// State table:
//   ST_IDLE  | accepting loader commands
//   ST_CLEAR | zeroing both RAMs, one address per cycle
module glitch_program_store
  import glitch_pkg::*;
#(
  parameter int INSTR_W    = 12,
  parameter int ADDR_W     = 8,
  parameter int DEPTH      = 256,
  parameter int DELAY_W    = 32,
  parameter int DLY_ADDR_W = 4,
  parameter int NUM_DELAYS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DELAY_W-1:0]    cmd_data,
  input  logic                  lock,
  input  logic [ADDR_W-1:0]     instr_pt,
  output logic [INSTR_W-1:0]    instr,
  output logic                  instr_valid,
  input  logic [DLY_ADDR_W-1:0] delay_num,
  output logic [DELAY_W-1:0]    delay_len,
  output logic [ADDR_W:0]       prog_len,
  output logic                  busy,
  output logic                  err,
  output logic [15:0]           checksum
);

  // Clear counter is one bit wider than either address so that DEPTH itself
  // (e.g. 256 with an 8-bit address) is representable in the compares.
  localparam int CNT_W   = ((ADDR_W > DLY_ADDR_W) ? ADDR_W : DLY_ADDR_W) + 1;
  localparam int CLR_CNT = (DEPTH > NUM_DELAYS) ? DEPTH : NUM_DELAYS;

  localparam logic [CNT_W-1:0]  CLR_LAST  = CNT_W'(CLR_CNT - 1);
  localparam logic [CNT_W-1:0]  CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_NDLY  = CNT_W'(NUM_DELAYS);
  localparam logic [ADDR_W:0]   LEN_MAX   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ADDR_NDLY = (ADDR_W+1)'(NUM_DELAYS);
  localparam logic [DLY_ADDR_W:0] IDX_NDLY = (DLY_ADDR_W+1)'(NUM_DELAYS);

  store_state_t state_q, state_d;

  logic [CNT_W-1:0]      clr_cnt;
  logic                  fetch_ok;
  logic                  delay_ok;
  logic                  accept;
  logic                  instr_addr_ok;
  logic                  delay_addr_ok;
  logic [ADDR_W:0]       len_req;
  logic [INSTR_W-1:0]    wr_word;

  logic                  iram_we;
  logic [ADDR_W-1:0]     iram_waddr;
  logic [INSTR_W-1:0]    iram_wdata;
  logic [INSTR_W-1:0]    iram_rdata;
  logic                  dram_we;
  logic [DLY_ADDR_W-1:0] dram_waddr;
  logic [DELAY_W-1:0]    dram_wdata;
  logic [DELAY_W-1:0]    dram_rdata;

  assign cmd_ready     = (state_q == ST_IDLE) && !lock;
  assign accept        = cmd_valid && cmd_ready;
  assign instr_addr_ok = {1'b0, cmd_addr} < LEN_MAX;
  assign delay_addr_ok = {1'b0, cmd_addr} < ADDR_NDLY;
  assign len_req       = cmd_data[ADDR_W:0];
  assign wr_word       = cmd_data[INSTR_W-1:0];
  assign busy          = (state_q == ST_CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus RAM write-port steering; the clear engine owns both
  // write ports while in ST_CLEAR, the loader owns them otherwise.
  always_comb begin
    state_d    = state_q;
    iram_we    = 1'b0;
    iram_waddr = cmd_addr;
    iram_wdata = wr_word;
    dram_we    = 1'b0;
    dram_waddr = cmd_addr[DLY_ADDR_W-1:0];
    dram_wdata = cmd_data;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_op)
            CMD_WR_INSTR: iram_we = instr_addr_ok;
            CMD_WR_DELAY: dram_we = delay_addr_ok;
            CMD_CLEAR:    state_d = ST_CLEAR;
            default:      ;
          endcase
        end
      end
      ST_CLEAR: begin
        iram_we    = clr_cnt < CNT_DEPTH;
        iram_waddr = clr_cnt[ADDR_W-1:0];
        iram_wdata = '0;
        dram_we    = clr_cnt < CNT_NDLY;
        dram_waddr = clr_cnt[DLY_ADDR_W-1:0];
        dram_wdata = '0;
        if (clr_cnt == CLR_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prog_len <= '0;
      checksum <= '0;
      err      <= 1'b0;
      clr_cnt  <= '0;
    end else if (state_q == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
    end else if (accept) begin
      case (cmd_op)
        CMD_WR_INSTR: begin
          if (instr_addr_ok) begin
            checksum <= checksum + 16'(wr_word);
          end else begin
            err <= 1'b1;
          end
        end
        CMD_WR_DELAY: begin
          if (!delay_addr_ok) begin
            err <= 1'b1;
          end
        end
        CMD_SET_LEN: begin
          if (len_req > LEN_MAX) begin
            prog_len <= LEN_MAX;
            err      <= 1'b1;
          end else begin
            prog_len <= len_req;
          end
        end
        default: begin
          prog_len <= '0;
          checksum <= '0;
          err      <= 1'b0;
          clr_cnt  <= '0;
        end
      endcase
    end
  end

  // Range qualifiers travel alongside the RAM read so data and valid line up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_ok <= 1'b0;
      delay_ok <= 1'b0;
    end else begin
      fetch_ok <= {1'b0, instr_pt} < prog_len;
      delay_ok <= {1'b0, delay_num} < IDX_NDLY;
    end
  end

  glitch_prog_ram #(
    .WIDTH   (INSTR_W),
    .DEPTH_W (ADDR_W)
  ) u_instr_ram (
    .clk   (clk),
    .we    (iram_we),
    .waddr (iram_waddr),
    .wdata (iram_wdata),
    .raddr (instr_pt),
    .rdata (iram_rdata)
  );

  glitch_prog_ram #(
    .WIDTH   (DELAY_W),
    .DEPTH_W (DLY_ADDR_W)
  ) u_delay_ram (
    .clk   (clk),
    .we    (dram_we),
    .waddr (dram_waddr),
    .wdata (dram_wdata),
    .raddr (delay_num),
    .rdata (dram_rdata)
  );

  assign instr       = fetch_ok ? iram_rdata : '0;
  assign instr_valid = fetch_ok;
  assign delay_len   = delay_ok ? dram_rdata : '0;

endmodule

// File: tb/tb_glitch_program_store.sv
// tb_glitch_program_store: self-checking bench for glitch_program_store.
// Fetch expectations go through a scoreboard queue tagged with the cycle in
// which the DUT output is due; status outputs are checked directly.
module tb_glitch_program_store;

  localparam int INSTR_W    = 12;
  localparam int ADDR_W     = 8;
  localparam int DEPTH      = 256;
  localparam int DELAY_W    = 32;
  localparam int DLY_ADDR_W = 4;
  localparam int NUM_DELAYS = 6;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [DELAY_W-1:0]    cmd_data;
  logic                  lock;
  logic [ADDR_W-1:0]     instr_pt;
  logic [INSTR_W-1:0]    instr;
  logic                  instr_valid;
  logic [DLY_ADDR_W-1:0] delay_num;
  logic [DELAY_W-1:0]    delay_len;
  logic [ADDR_W:0]       prog_len;
  logic                  busy;
  logic                  err;
  logic [15:0]           checksum;

  glitch_program_store #(
    .INSTR_W    (INSTR_W),
    .ADDR_W     (ADDR_W),
    .DEPTH      (DEPTH),
    .DELAY_W    (DELAY_W),
    .DLY_ADDR_W (DLY_ADDR_W),
    .NUM_DELAYS (NUM_DELAYS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .lock        (lock),
    .instr_pt    (instr_pt),
    .instr       (instr),
    .instr_valid (instr_valid),
    .delay_num   (delay_num),
    .delay_len   (delay_len),
    .prog_len    (prog_len),
    .busy        (busy),
    .err         (err),
    .checksum    (checksum)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0]     pt;
    logic [DLY_ADDR_W-1:0] dn;
    logic [INSTR_W-1:0]    e_instr;
    logic                  e_valid;
    logic [DELAY_W-1:0]    e_delay;
  } vec_t;

  typedef struct {
    logic [INSTR_W-1:0] e_instr;
    logic               e_valid;
    logic [DELAY_W-1:0] e_delay;
    int                 due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      check("fetch_instr", 32'(instr), 32'(mon_e.e_instr));
      check("fetch_valid", 32'(instr_valid), 32'(mon_e.e_valid));
      check("fetch_delay", delay_len, mon_e.e_delay);
    end
  end

  // Drives a fetch on the current negedge; result due after the next posedge.
  task automatic push_fetch(input logic [ADDR_W-1:0] pt, input logic [DLY_ADDR_W-1:0] dn,
                            input logic [INSTR_W-1:0] ei, input logic ev, input logic [DELAY_W-1:0] ed);
    instr_pt  = pt;
    delay_num = dn;
    sb.push_back('{ei, ev, ed, cyc + 1});
  endtask

  task automatic fetch(input logic [ADDR_W-1:0] pt, input logic [DLY_ADDR_W-1:0] dn,
                       input logic [INSTR_W-1:0] ei, input logic ev, input logic [DELAY_W-1:0] ed);
    @(negedge clk);
    push_fetch(pt, dn, ei, ev, ed);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    check("scoreboard_drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Returns on the negedge following the transfer edge.
  task automatic do_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] addr, input logic [DELAY_W-1:0] data);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    n = 0;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic clear_and_count(input string name);
    int cnt;
    do_cmd(2'b11, '0, '0);
    cnt = 0;
    while (busy && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    check(name, 32'(cnt), 32'd256);
  endtask

  vec_t vecs[5];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'd0, 4'd1,  12'h308, 1'b1, 32'h000F4240};
    vecs[1] = '{8'd1, 4'd15, 12'h202, 1'b1, 32'h0};
    vecs[2] = '{8'd2, 4'd1,  12'h000, 1'b0, 32'h000F4240};
    vecs[3] = '{8'd0, 4'd7,  12'h308, 1'b1, 32'h0};
    vecs[4] = '{8'd1, 4'd2,  12'h202, 1'b1, 32'h0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
    lock = 1'b0; instr_pt = '0; delay_num = '0;
    repeat (3) @(negedge clk);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_delay_len", delay_len, 32'd0);
    check("rst_prog_len", 32'(prog_len), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    clear_and_count("init_clear_cycles");

    // Program load and checksum
    do_cmd(2'b00, 8'd0, 32'h308);
    do_cmd(2'b00, 8'd1, 32'h202);
    do_cmd(2'b10, 8'd0, 32'd2);
    check("load_checksum", 32'(checksum), 32'h050A);
    check("load_prog_len", 32'(prog_len), 32'd2);

    // Delay writes, in range and out of range
    do_cmd(2'b01, 8'd1, 32'h000F4240);
    check("delay_ok_err", 32'(err), 32'd0);
    do_cmd(2'b01, 8'd7, 32'h12345678);
    check("delay_oob_err", 32'(err), 32'd1);

    for (int i = 0; i < 5; i++) fetch(vecs[i].pt, vecs[i].dn, vecs[i].e_instr, vecs[i].e_valid, vecs[i].e_delay);
    drain();

    // Lock blocks acceptance; release is accepted in the same cycle
    @(negedge clk);
    lock = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 8'd5; cmd_data = 32'h123;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lock_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    check("lock_checksum", 32'(checksum), 32'h050A);
    lock = 1'b0;
    #1;
    check("unlock_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("unlock_checksum", 32'(checksum), 32'h062D);

    // Read-during-write to the same address returns the old word
    do_cmd(2'b10, 8'd0, 32'd4);
    check("rdw_prog_len", 32'(prog_len), 32'd4);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 8'd3; cmd_data = 32'h38E;
    push_fetch(8'd3, 4'd0, 12'h000, 1'b1, 32'h0);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    push_fetch(8'd3, 4'd0, 12'h38E, 1'b1, 32'h0);
    drain();
    check("rdw_checksum", 32'(checksum), 32'h09BB);

    // Length clamp, then clear wipes status and contents
    clear_and_count("clear2_cycles");
    check("clear2_err", 32'(err), 32'd0);
    do_cmd(2'b10, 8'd0, 32'd300);
    check("clamp_prog_len", 32'(prog_len), 32'd256);
    check("clamp_err", 32'(err), 32'd1);
    clear_and_count("clear3_cycles");
    check("clear3_err", 32'(err), 32'd0);
    check("clear3_prog_len", 32'(prog_len), 32'd0);
    check("clear3_checksum", 32'(checksum), 32'd0);
    fetch(8'd3, 4'd1, 12'h000, 1'b0, 32'h0);
    drain();
    do_cmd(2'b10, 8'd0, 32'd256);
    check("full_prog_len", 32'(prog_len), 32'd256);
    check("full_err", 32'(err), 32'd0);
    fetch(8'd0,   4'd1, 12'h000, 1'b1, 32'h0);
    fetch(8'd1,   4'd0, 12'h000, 1'b1, 32'h0);
    fetch(8'd3,   4'd5, 12'h000, 1'b1, 32'h0);
    fetch(8'd5,   4'd2, 12'h000, 1'b1, 32'h0);
    fetch(8'd255, 4'd0, 12'h000, 1'b1, 32'h0);
    drain();

    // Reset in the middle of a clear
    do_cmd(2'b11, '0, '0);
    repeat (10) @(negedge clk);
    check("midclr_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midclr_busy", 32'(busy), 32'd0);
    check("midclr_prog_len", 32'(prog_len), 32'd0);
    check("midclr_instr_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_and_count("post_rst_clear_cycles");
    check("post_rst_prog_len", 32'(prog_len), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/glitch_program_store.md
Name: glitch_program_store

Overview:
Writable, parametrised program and delay store for the glitch sequencer. It replaces the fixed instruction/delay lookup with two synchronous RAMs that a host loader fills over a valid/ready command port. The sequencer fetches instructions by `instr_pt` and delay lengths by `delay_num`, as before. Adds a program-length register, a bulk-clear engine, a write lock while the sequencer runs, a sticky error flag and a load checksum.

Parameters:
INSTR_W, 12, instruction width {op[1:0], bus, data[7:0], ack}
ADDR_W, 8, instruction address width
DEPTH, 256, instruction words implemented (<= 2**ADDR_W)
DELAY_W, 32, delay length width
DLY_ADDR_W, 4, delay index width
NUM_DELAYS, 16, delay entries implemented (<= 2**DLY_ADDR_W)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  loader command valid
cmd_ready  out  1  store accepts command this cycle
cmd_op  in  2  00 write instr, 01 write delay, 10 set prog_len, 11 clear all
cmd_addr  in  ADDR_W  target address (delay uses low DLY_ADDR_W bits)
cmd_data  in  DELAY_W  write data (instr uses low INSTR_W bits; prog_len uses low ADDR_W+1 bits)
lock  in  1  sequencer running; blocks command acceptance
instr_pt  in  ADDR_W  instruction fetch address
instr  out  INSTR_W  fetched instruction
instr_valid  out  1  instr_pt was < prog_len
delay_num  in  DLY_ADDR_W  delay fetch index
delay_len  out  DELAY_W  fetched delay length
prog_len  out  ADDR_W+1  current program length
busy  out  1  clear in progress
err  out  1  sticky error
checksum  out  16  running sum of accepted instruction words, mod 2**16

Behaviour:
- Reset (async): state IDLE; instr=0, instr_valid=0, delay_len=0, prog_len=0, busy=0, err=0, checksum=0. RAM contents are not reset.
- Handshake: a command transfers when cmd_valid && cmd_ready. cmd_ready = (state==IDLE) && !lock. The loader holds cmd_* stable until the transfer.
- FSM states: IDLE, CLEAR.
- IDLE, op 00:
  - addr < DEPTH: write RAM[addr] = cmd_data[INSTR_W-1:0]; checksum += zero-extended word.
  - otherwise: drop the write; err=1.
- IDLE, op 01:
  - addr < NUM_DELAYS: write the delay entry.
  - otherwise: drop the write; err=1.
- IDLE, op 10: prog_len = min(data, DEPTH); err=1 if data > DEPTH.
- IDLE, op 11: enter CLEAR.
  - On entry: prog_len=0, checksum=0, err=0, clear counter=0, busy=1.
- CLEAR: write zero to both RAMs at the counter address (delay RAM only while counter < NUM_DELAYS). Increment the counter each cycle.
  - Exit to IDLE after writing address max(DEPTH,NUM_DELAYS)-1.
  - busy drops the cycle IDLE is re-entered.
  - Total: max(DEPTH,NUM_DELAYS) cycles.
- lock asserting during CLEAR does not stop the clear. It only gates acceptance of the next command.
- Fetch: registered, latency 1 cycle.
  - instr = RAM[instr_pt] and instr_valid=1 if instr_pt < prog_len; else instr=0, instr_valid=0.
  - delay_len = entry if delay_num < NUM_DELAYS, else 0.
- Read-during-write to the same address returns the old data. The new data is visible on the next fetch.
- Reset mid-CLEAR: returns to IDLE immediately. prog_len=0 keeps instr_valid low over the partially cleared RAM.
- Checksum wraps modulo 2**16. Rewriting an address adds again; the checksum is not a content hash.

Decomposition:
- Shared package glitch_pkg:
  - opcode constants I2C_CHK=2'b00, DAC_UP=2'b01, DELAY=2'b10
  - PRIV_BUS=1'b1, MAIN_BUS=1'b0, ACK=1'b0, NAK=1'b1
  - command opcode constants CMD_WR_INSTR, CMD_WR_DELAY, CMD_SET_LEN, CMD_CLEAR
  - FSM state typedef
- Sub-module glitch_prog_ram: generic 1W1R synchronous RAM (WIDTH, DEPTH_W). Instantiated once for instructions and once for delays.

Test Plan:
- Reset, then write instr 0=12'h308 and 1=12'h202, set prog_len=2, fetch pt 0,1,2 -> instr 12'h308/v=1, 12'h202/v=1, 0/v=0, each one cycle after the address; checksum=16'h050A.
- Write delay 1=32'h000F4240, fetch delay_num=1 then 15 (unwritten after clear) -> 32'h000F4240 then 0; with NUM_DELAYS=6, write to index 7 -> dropped, err=1.
- Assert lock with cmd_valid high and op 00 -> cmd_ready=0, no write, checksum unchanged; deassert lock -> accepted the same cycle.
- Set prog_len=300 with DEPTH=256 -> prog_len=256, err=1; then clear -> err=0, prog_len=0, busy high for exactly 256 cycles, all fetches return 0.
- Write instr 3=12'h38E while fetching pt 3 in the same cycle (prog_len=4, old value 12'h000) -> first fetch 12'h000, next fetch 12'h38E.
- Assert rst 10 cycles into a clear -> busy=0, prog_len=0, instr_valid=0 at once; the next clear completes normally.
